pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined successor to the team's single-bit half/full adder blocks. It computes `A + B + Cin` (or `A - B - Bin` in subtract mode) on WIDTH-bit operands. The carry chain is split into STAGES registered chunks. A valid/ready handshake lets it sit in a streaming datapath between a producer and a consumer that can apply backpressure. Throughput is one operation per cycle.

## Interface
- WIDTH, 16, operand/result width in bits; must be divisible by STAGES (elaboration error otherwise).
- STAGES, 4, number of pipeline register stages, ≥1; chunk width CW = WIDTH/STAGES.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- Data_in_A  input  WIDTH  operand A.
- Data_in_B  input  WIDTH  operand B.
- Data_in_C  input  1  carry-in (add) / borrow-in (subtract).
- Data_in_Sub  input  1  0 = add, 1 = subtract.
- in_valid  input  1  operands valid this cycle.
- in_ready  output  1  block can accept operands this cycle.
- Data_out_Sum  output  WIDTH  result.
- Data_out_Carry  output  1  carry-out (add) / not-borrow (subtract).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result this cycle.
- Data_out_Overflow  output  1  signed overflow; present only with ADDER_OVERFLOW_EN.

## Operation
- Effective operands at acceptance:
  - Bx = Sub ? ~B : B.
  - cin = Sub ? ~C : C.
  - Result = A + Bx + cin, computed mod 2^WIDTH, with carry = bit WIDTH.
  - Subtract therefore yields A − B − C; Carry=1 means no borrow.
- Operands are accepted on a rising edge when in_valid && in_ready.
- Stage i (0..STAGES−1) adds chunk i, i.e. bits [i·CW +: CW] of A and Bx, plus the carry registered by stage i−1. Stage 0 uses cin.
- Upper operand chunks are skew-delayed, so each chunk reaches its adder in the same cycle as its incoming carry.
- Lower result chunks are deskew-delayed, so all WIDTH bits and the final carry emerge together.
- Each stage carries a valid bit. The output registers are the last stage; out_valid is the last stage's valid bit.
- Stall rule: stall = out_valid && !out_ready.
  - in_ready = !stall, combinational.
  - On stall, every stage register (data and valid) holds.
  - Bubbles are not collapsed during a stall.
- When not stalled, every stage advances each edge. A stage whose predecessor is invalid loads valid=0; its data is don't-care.
- Reset (async, any time): all valid bits clear immediately and in-flight operations are discarded. Data_out_Sum=0, Data_out_Carry=0, Data_out_Overflow=0, out_valid=0. in_ready=1 once out_valid is 0.

## Timing
- Latency: an operation accepted on edge k sets out_valid after edge k+STAGES−1, i.e. it is visible STAGES cycles after acceptance. STAGES=1 gives one cycle.
- Throughput: one result per cycle while out_ready=1; back-to-back in_valid is fully accepted.
- Simultaneous events:
  - Output handshake plus input accept in the same cycle is legal: the pipeline advances and no stall occurs.
  - in_valid held with in_ready=0: the operands are not accepted. The producer must hold them; the block never samples them.
- out_valid and the result stay stable while stalled until out_ready=1.
- Release of rst is sampled synchronously; the first accept is possible on the first edge after deassertion.
- Critical path: one CW-bit ripple chain plus register.

## Configuration
- ADDER_OVERFLOW_EN defined:
  - Data_out_Overflow exists and is pipelined with the result.
  - It is computed as carry into the MSB XOR carry out of the MSB, for the effective operation.
  - It is reset to 0.
- ADDER_OVERFLOW_EN undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- WIDTH=16, STAGES=4, out_ready=1: A=0xFFFF, B=0x0001, C=0, Sub=0 → Sum=0x0000, Carry=1, out_valid exactly 4 cycles after accept.
- Subtract: A=0x0005, B=0x0007, C=0, Sub=1 → Sum=0xFFFE, Carry=0. A=0x0007, B=0x0005, C=1 → Sum=0x0001, Carry=1.
- Streaming: 8 back-to-back ops (A=i, B=i, C=1, i=0..7) → 8 consecutive results 2i+1, in order, no gaps.
- Backpressure: out_ready=0 for 5 cycles with the pipe full → in_ready=0, output held stable. out_ready=1 → all 4 results drain in order with none lost or duplicated.
- Reset mid-flight: assert rst with 3 ops in flight → out_valid=0 and Sum=0 immediately; no stale result appears after release.
- With ADDER_OVERFLOW_EN: A=0x7FFF, B=0x0001, add → Sum=0x8000, Overflow=1. A=0x8000, B=0x0001, Sub=1 → Sum=0x7FFF, Overflow=1.

Source files
------------

// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result bundle with valid/ready handshake for pipelined_adder
// ADDER_OVERFLOW_EN adds the Data_out_Overflow signal.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] Data_in_A;
    logic [WIDTH-1:0] Data_in_B;
    logic             Data_in_C;
    logic             Data_in_Sub;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Data_out_Sum;
    logic             Data_out_Carry;
    logic             out_valid;
    logic             out_ready;
`ifdef ADDER_OVERFLOW_EN
    logic             Data_out_Overflow;
`endif
    modport master (
        output Data_in_A, Data_in_B, Data_in_C, Data_in_Sub, in_valid, out_ready,
        input  in_ready, Data_out_Sum, Data_out_Carry, out_valid
`ifdef ADDER_OVERFLOW_EN
        , input Data_out_Overflow
`endif
    );
    modport slave (
        input  Data_in_A, Data_in_B, Data_in_C, Data_in_Sub, in_valid, out_ready,
        output in_ready, Data_out_Sum, Data_out_Carry, out_valid
`ifdef ADDER_OVERFLOW_EN
        , output Data_out_Overflow
`endif
    );
endinterface

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep chunked add/subtract with valid/ready flow control; ADDER_OVERFLOW_EN adds signed overflow.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic clk,
    input logic rst,
    pipelined_adder_if.slave io
);
    localparam int CW = WIDTH / STAGES;

    if (STAGES < 1 || WIDTH % STAGES != 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    logic              stall;
    logic [WIDTH-1:0]  bx;
    logic              cin;
    logic [STAGES-1:0] v;
    logic [WIDTH-1:0]  sum;

    assign stall           = io.out_valid && !io.out_ready;
    assign io.in_ready     = !stall;
    assign bx              = io.Data_in_Sub ? ~io.Data_in_B : io.Data_in_B;
    assign cin             = io.Data_in_Sub ? ~io.Data_in_C : io.Data_in_C;
    assign io.out_valid    = v[STAGES-1];
    assign io.Data_out_Sum = sum;

    // valid bits shift one stage per unstalled edge
    always_ff @(posedge clk or posedge rst)
        if (rst) v <= '0;
        else if (!stall) v <= STAGES'({v, io.in_valid});

    for (genvar j = 0; j < STAGES; j++) begin : g
        logic [CW-1:0] a_op, b_op, s;
        logic          ci, co, co_q;
        logic [CW-1:0] sd [STAGES-j];
        if (j == 0) begin : g_skew
            assign a_op = io.Data_in_A[CW-1:0];
            assign b_op = bx[CW-1:0];
            assign ci   = cin;
        end else begin : g_skew
            logic [CW-1:0] ad [j];
            logic [CW-1:0] bd [j];
            // delay chunk j operands so they meet the carry from chunk j-1
            always_ff @(posedge clk or posedge rst)
                if (rst) begin
                    for (int k = 0; k < j; k++) begin
                        ad[k] <= '0;
                        bd[k] <= '0;
                    end
                end else if (!stall) begin
                    ad[0] <= io.Data_in_A[j*CW +: CW];
                    bd[0] <= bx[j*CW +: CW];
                    for (int k = 1; k < j; k++) begin
                        ad[k] <= ad[k-1];
                        bd[k] <= bd[k-1];
                    end
                end
            assign a_op = ad[j-1];
            assign b_op = bd[j-1];
            assign ci   = g[j-1].co_q;
        end
        assign {co, s} = {1'b0, a_op} + {1'b0, b_op} + {{CW{1'b0}}, ci};
        // register chunk carry and hold the chunk result until the top chunk catches up
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                co_q <= 1'b0;
                for (int k = 0; k < STAGES - j; k++) sd[k] <= '0;
            end else if (!stall) begin
                co_q  <= co;
                sd[0] <= s;
                for (int k = 1; k < STAGES - j; k++) sd[k] <= sd[k-1];
            end
        assign sum[j*CW +: CW] = sd[STAGES-1-j];
    end

    assign io.Data_out_Carry = g[STAGES-1].co_q;

`ifdef ADDER_OVERFLOW_EN
    // carry into MSB is a^b^s at the MSB, so overflow is that XOR carry out
    always_ff @(posedge clk or posedge rst)
        if (rst) io.Data_out_Overflow <= 1'b0;
        else if (!stall) io.Data_out_Overflow <= g[STAGES-1].a_op[CW-1] ^ g[STAGES-1].b_op[CW-1]
                                                ^ g[STAGES-1].s[CW-1] ^ g[STAGES-1].co;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed self-checking bench for pipelined_adder (WIDTH=16, STAGES=4)
module tb_pipelined_adder;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    pipelined_adder_if #(.WIDTH(16)) io ();

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk),
        .rst(rst),
        .io (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic c, input logic sub);
        io.Data_in_A   = a;
        io.Data_in_B   = b;
        io.Data_in_C   = c;
        io.Data_in_Sub = sub;
        io.in_valid    = 1'b1;
    endtask

    task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic sub, input logic [15:0] es, input logic ec, input logic eov);
        drive(a, b, c, sub);
        chk({tag, "_rdy"}, 17'(io.in_ready), 17'd1);
        tick();
        io.in_valid = 1'b0;
        for (int n = 1; n < 4; n++) begin
            chk({tag, "_lat"}, 17'(io.out_valid), 17'd0);
            tick();
        end
        chk({tag, "_vld"}, 17'(io.out_valid), 17'd1);
        chk({tag, "_sum"}, 17'(io.Data_out_Sum), 17'(es));
        chk({tag, "_cry"}, 17'(io.Data_out_Carry), 17'(ec));
`ifdef ADDER_OVERFLOW_EN
        chk({tag, "_ov"}, 17'(io.Data_out_Overflow), 17'(eov));
`else
        if (eov === 1'bx) $display("note: %s overflow unknown", tag);
`endif
        tick();
        chk({tag, "_end"}, 17'(io.out_valid), 17'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        io.Data_in_A = '0;
        io.Data_in_B = '0;
        io.Data_in_C = 1'b0;
        io.Data_in_Sub = 1'b0;
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        #1;
        chk("rst_vld", 17'(io.out_valid), 17'd0);
        chk("rst_sum", 17'(io.Data_out_Sum), 17'd0);
        chk("rst_cry", 17'(io.Data_out_Carry), 17'd0);
        chk("rst_rdy", 17'(io.in_ready), 17'd1);
`ifdef ADDER_OVERFLOW_EN
        chk("rst_ov", 17'(io.Data_out_Overflow), 17'd0);
`endif
        tick();
        rst = 1'b0;

        op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op("sub_pos", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
        op("cross", 16'h0FF0, 16'h0010, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);
        op("ov_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        op("ov_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        for (int n = 0; n < 11; n++) begin
            if (n < 8) drive(16'(n), 16'(n), 1'b1, 1'b0);
            else io.in_valid = 1'b0;
            chk("stream_rdy", 17'(io.in_ready), 17'd1);
            tick();
            if (n >= 3) begin
                chk("stream_vld", 17'(io.out_valid), 17'd1);
                chk("stream_sum", 17'(io.Data_out_Sum), 17'(2 * (n - 3) + 1));
            end
        end
        tick();
        chk("stream_end", 17'(io.out_valid), 17'd0);

        io.out_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            drive(16'(16'h0020 + n), 16'h0100, 1'b0, 1'b0);
            tick();
        end
        drive(16'h0024, 16'h0100, 1'b0, 1'b0);
        for (int n = 0; n < 5; n++) begin
            chk("bp_rdy", 17'(io.in_ready), 17'd0);
            chk("bp_vld", 17'(io.out_valid), 17'd1);
            chk("bp_sum", 17'(io.Data_out_Sum), 17'h00120);
            tick();
        end
        io.out_ready = 1'b1;
        #1;
        chk("bp_rel_rdy", 17'(io.in_ready), 17'd1);
        for (int n = 1; n < 5; n++) begin
            tick();
            io.in_valid = 1'b0;
            chk("drain_vld", 17'(io.out_valid), 17'd1);
            chk("drain_sum", 17'(io.Data_out_Sum), 17'(16'h0120 + n));
        end
        tick();
        chk("drain_end", 17'(io.out_valid), 17'd0);

        for (int n = 0; n < 3; n++) begin
            drive(16'h1111, 16'h2222, 1'b0, 1'b0);
            tick();
        end
        io.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_vld", 17'(io.out_valid), 17'd0);
        chk("mid_rst_sum", 17'(io.Data_out_Sum), 17'd0);
        chk("mid_rst_rdy", 17'(io.in_ready), 17'd1);
        tick();
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            chk("stale", 17'(io.out_valid), 17'd0);
        end
        op("post_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
